program_loader: RTL

Boot-time writer for the byte-addressed instruction memory. It accepts a program as a byte stream over a valid/ready handshake and packs each group of four bytes into a big-endian 32-bit word, first byte in bits 31:24. Each word is written through the memory's word write port at consecutive byte addresses, in exactly the layout the fetch path reads back. The block holds the CPU in reset until the load completes.

---
 rtl/program_loader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader: boot-time instruction memory writer.
// Packs a valid/ready byte stream into big-endian 32-bit words, first byte in
// bits 31:24, and writes them to consecutive word addresses. The CPU is held
// in reset until every requested word has been written.
module program_loader #(
    parameter int MEM_BYTES = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] word_count,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold,
    output logic [7:0]  checksum
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]  r_state;
    logic [31:0] r_addr;
    logic [15:0] r_remaining;
    logic [1:0]  r_cnt;
    logic [23:0] r_word;
    logic [7:0]  r_checksum;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic        w_start_ok;
    logic        w_misaligned;
    logic        w_oob;
    logic [33:0] w_end;
    logic        w_accept;

    // The end address is formed in 34 bits so a huge base or count can never
    // wrap around and slip past the bounds check.
    assign w_end        = {2'b00, base_addr} + {16'b0, word_count, 2'b00};
    assign w_oob        = (w_end > 34'(MEM_BYTES));
    assign w_misaligned = (base_addr[1:0] != 2'b00);
    assign w_start_ok   = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                    (r_state == S_ERR));
    assign w_accept     = (r_state == S_RECV) && in_valid;

    // Control FSM: start checks, byte counting, address/word bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= 32'd0;
            r_remaining <= 16'd0;
            r_cnt       <= 2'd0;
            r_checksum  <= 8'd0;
        end else if (w_start_ok) begin
            r_addr      <= base_addr;
            r_remaining <= word_count;
            r_cnt       <= 2'd0;
            r_checksum  <= 8'd0;
            if (w_misaligned || w_oob) begin
                r_state <= S_ERR;
            end else if (word_count == 16'd0) begin
                r_state <= S_DONE;
            end else begin
                r_state <= S_RECV;
            end
        end else begin
            case (r_state)
                S_RECV: begin
                    if (w_accept) begin
                        r_checksum <= r_checksum + in_data;
                        r_cnt      <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    r_addr      <= r_addr + 32'd4;
                    r_remaining <= r_remaining - 16'd1;
                    r_state     <= (r_remaining == 16'd1) ? S_DONE : S_RECV;
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    // Word assembly and the registered write port; the port keeps the last
    // written address/data between writes so the memory sees stable values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word      <= 24'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
        end else if (w_start_ok) begin
            r_word <= 24'd0;
        end else if (w_accept) begin
            r_word <= {r_word[15:0], in_data};
            if (r_cnt == 2'd3) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= {r_word, in_data};
            end
        end
    end

    assign in_ready  = (r_state == S_RECV);
    assign mem_we    = (r_state == S_WRITE);
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state == S_RECV) || (r_state == S_WRITE);
    assign done      = (r_state == S_DONE);
    assign error     = (r_state == S_ERR);
    assign cpu_hold  = (r_state != S_DONE);
    assign checksum  = r_checksum;

endmodule
